// File: rtl/clkctrl_pkg.sv
// Shared types and helpers for the single-clock PHI2 generator.
package clkctrl_pkg;

  typedef enum logic [1:0] {
    LS_RUN   = 2'd0,
    HS_RUN   = 2'd1,
    HS_TO_LS = 2'd2
  } clk_state_e;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  // Half-period counter reload: the phase lasts (reload + 1) = 2^sel cycles.
  function automatic int unsigned half_reload(input int unsigned sel);
    return (32'd1 << sel) - 32'd1;
  endfunction

endpackage

// File: rtl/clkctrl_sync_bit.sv
// Multi-flop synchroniser for a single asynchronous bit, cleared to 0 on reset.
module clkctrl_sync_bit
  import clkctrl_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_b,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  generate
    if (STAGES < SYNC_STAGES_MIN || STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
      $error("clkctrl_sync_bit: STAGES out of range");
    end
  endgenerate

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/clkctrl_phi2_gen.sv
// PHI2 generator on the fast clock, switching glitch-free between divided fast and synchronised slow clocks.
// Optional high-phase stretching is built when CLKCTRL_STRETCH_EN is defined.
module clkctrl_phi2_gen
  import clkctrl_pkg::*;
#(
  parameter int DIV_SEL_W   = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 hsclk_in,
  input  logic                 rst_b,
  input  logic                 lsclk_in,
  input  logic                 hsclk_sel,
  input  logic [DIV_SEL_W-1:0] div_sel,
  input  logic                 stretch_req,
  output logic                 phi2_q,
  output logic                 cycle_end_stb,
  output logic                 hsclk_selected,
  output logic                 lsclk_selected,
  output logic [DIV_SEL_W-1:0] div_active
);

  localparam int CNT_W = (1 << DIV_SEL_W) - 1;

  clk_state_e           state_q, state_d;
  logic                 phi2_d;
  logic                 cycle_end_stb_q, cycle_end_stb_d;
  logic [DIV_SEL_W-1:0] div_active_q, div_active_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ls_s_prev_q;
  logic                 ls_s;
  logic                 ls_fall;
  logic                 stretch_hold;
  logic                 hs_fall;

  function automatic logic [CNT_W-1:0] reload_of(input logic [DIV_SEL_W-1:0] sel);
    return CNT_W'(half_reload(int'(sel)));
  endfunction

  clkctrl_sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_ls_sync (
    .clk  (hsclk_in),
    .rst_b(rst_b),
    .d    (lsclk_in),
    .q    (ls_s)
  );

  assign ls_fall = ls_s_prev_q & ~ls_s;

`ifdef CLKCTRL_STRETCH_EN
  assign stretch_hold = stretch_req & phi2_q & (cnt_q == '0);
`else
  assign stretch_hold = 1'b0 & stretch_req;
`endif

  // The only place a fast-mode cycle ends; ratio and mode changes are taken here.
  assign hs_fall = (state_q == HS_RUN) & phi2_q & (cnt_q == '0) & ~stretch_hold;

  always_ff @(posedge hsclk_in) begin
    if (!rst_b) begin
      state_q         <= LS_RUN;
      phi2_q          <= 1'b0;
      cycle_end_stb_q <= 1'b0;
      div_active_q    <= '0;
      cnt_q           <= '0;
      ls_s_prev_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      phi2_q          <= phi2_d;
      cycle_end_stb_q <= cycle_end_stb_d;
      div_active_q    <= div_active_d;
      cnt_q           <= cnt_d;
      ls_s_prev_q     <= ls_s;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LS_RUN:   if (ls_fall && hsclk_sel) state_d = HS_RUN;
      HS_RUN:   if (hs_fall && !hsclk_sel) state_d = HS_TO_LS;
      HS_TO_LS: begin
        if (hsclk_sel) begin
          state_d = HS_RUN;
        end else if (ls_fall) begin
          state_d = LS_RUN;
        end
      end
      default:  state_d = LS_RUN;
    endcase
  end

  always_comb begin
    phi2_d          = phi2_q;
    cycle_end_stb_d = 1'b0;
    div_active_d    = div_active_q;
    cnt_d           = cnt_q;
    unique case (state_q)
      LS_RUN: begin
        phi2_d          = ls_s;
        cycle_end_stb_d = ls_fall;
        if (ls_fall && hsclk_sel) begin
          phi2_d       = 1'b0;
          div_active_d = div_sel;
          cnt_d        = reload_of(div_sel);
        end
      end
      HS_RUN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (hs_fall) begin
          phi2_d          = 1'b0;
          cycle_end_stb_d = 1'b1;
          div_active_d    = div_sel;
          cnt_d           = reload_of(div_sel);
        end else if (!phi2_q) begin
          phi2_d = 1'b1;
          cnt_d  = reload_of(div_active_q);
        end
      end
      HS_TO_LS: begin
        phi2_d = 1'b0;
        if (hsclk_sel) begin
          div_active_d = div_sel;
          cnt_d        = reload_of(div_sel);
        end
      end
      default: phi2_d = 1'b0;
    endcase
  end

  always_comb begin
    hsclk_selected = (state_q == HS_RUN);
    lsclk_selected = (state_q == LS_RUN);
    cycle_end_stb  = cycle_end_stb_q;
    div_active     = div_active_q;
  end

endmodule

// File: tb/tb_clkctrl_phi2_gen.sv
// Directed bench for clkctrl_phi2_gen: slow follow, switch to fast, ratio change, switch back, abort, stretch, reset.
module tb_clkctrl_phi2_gen;

  logic       hsclk_in = 1'b0;
  logic       rst_b;
  logic       lsclk_in;
  logic       hsclk_sel;
  logic [1:0] div_sel;
  logic       stretch_req;
  logic       phi2_q;
  logic       cycle_end_stb;
  logic       hsclk_selected;
  logic       lsclk_selected;
  logic [1:0] div_active;

  int errors = 0;
  int checks = 0;
  int k = 0;
  int stb_seen = 0;

  clkctrl_phi2_gen #(
    .DIV_SEL_W  (2),
    .SYNC_STAGES(2)
  ) dut (
    .hsclk_in      (hsclk_in),
    .rst_b         (rst_b),
    .lsclk_in      (lsclk_in),
    .hsclk_sel     (hsclk_sel),
    .div_sel       (div_sel),
    .stretch_req   (stretch_req),
    .phi2_q        (phi2_q),
    .cycle_end_stb (cycle_end_stb),
    .hsclk_selected(hsclk_selected),
    .lsclk_selected(lsclk_selected),
    .div_active    (div_active)
  );

  always #5 hsclk_in = ~hsclk_in;

  // Slow clock pattern: 8 cycles high then 8 low, indexed by the edge after which it is driven.
  function automatic logic wave(input int j);
    return (j % 16) < 8;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at edge %0d: observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic expect4(input logic p, input logic s, input logic [1:0] sel, input logic [1:0] d);
    chk("phi2_q", 8'(p), 8'(p));
    chk("phi2_q_val", 8'(phi2_q), 8'(p));
    chk("cycle_end_stb", 8'(cycle_end_stb), 8'(s));
    chk("hs_ls_selected", 8'({hsclk_selected, lsclk_selected}), 8'(sel));
    chk("div_active", 8'(div_active), 8'(d));
  endtask

  task automatic tick();
    @(posedge hsclk_in);
    #1;
    k++;
  endtask

  initial begin
    rst_b       = 1'b0;
    lsclk_in    = 1'b0;
    hsclk_sel   = 1'b0;
    div_sel     = 2'd0;
    stretch_req = 1'b0;
    repeat (3) tick();
    expect4(1'b0, 1'b0, 2'b01, 2'd0);

    // Slow mode: phi2 trails lsclk_in by three edges; fast mode requested after edge 48.
    k        = 0;
    rst_b    = 1'b1;
    lsclk_in = wave(0);
    for (int i = 1; i <= 58; i++) begin
      tick();
      expect4((k >= 3) ? wave(k - 3) : 1'b0,
              (k >= 4) ? (wave(k - 4) & ~wave(k - 3)) : 1'b0,
              2'b01, 2'd0);
      if (k <= 48 && cycle_end_stb) stb_seen++;
      if (k == 48) begin
        hsclk_sel = 1'b1;
        div_sel   = 2'd1;
      end
      lsclk_in = wave(k);
    end
    chk("stb_per_slow_period", 8'(stb_seen), 8'd3);

    // Fast mode, divide by 4: 2 low / 2 high starting at edge 59.
    for (int i = 59; i <= 74; i++) begin
      tick();
      expect4(((k - 59) % 4) >= 2, ((k - 59) % 4) == 0, 2'b10, 2'd1);
      lsclk_in = wave(k);
    end
    div_sel = 2'd0;

    // Divide by 2 after the fall at edge 75.
    for (int i = 75; i <= 80; i++) begin
      tick();
      expect4(((k - 75) % 2) == 1, ((k - 75) % 2) == 0, 2'b10, 2'd0);
      lsclk_in = wave(k);
    end
    div_sel = 2'd3;

    // Ratio 3 takes effect at the fall: 8 low, 8 high; a stray hsclk_sel dip mid-phase is ignored.
    for (int i = 81; i <= 96; i++) begin
      tick();
      expect4(k >= 89, k == 81, 2'b10, 2'd3);
      if (k == 85) hsclk_sel = 1'b0;
      if (k == 86) hsclk_sel = 1'b1;
      if (k == 90) div_sel = 2'd0;
      if (k == 92) hsclk_sel = 1'b0;
      lsclk_in = wave(k);
    end

    // High phase completes, then phi2 held low in the handover until the slow fall at edge 107.
    for (int i = 97; i <= 107; i++) begin
      tick();
      expect4(1'b0, k == 97, (k == 107) ? 2'b01 : 2'b00, 2'd0);
      lsclk_in = wave(k);
    end

    // Back in slow mode following lsclk_in; fast requested again at div 2 after edge 120.
    for (int i = 108; i <= 122; i++) begin
      tick();
      expect4(wave(k - 3), wave(k - 4) & ~wave(k - 3), 2'b01, 2'd0);
      if (k == 120) begin
        hsclk_sel = 1'b1;
        div_sel   = 2'd2;
      end
      lsclk_in = wave(k);
    end

    // Fast at div 2, drop to handover at edge 131, return to fast before any slow fall.
    for (int i = 123; i <= 140; i++) begin
      tick();
      expect4((k >= 127 && k <= 130) || (k >= 136 && k <= 137) || k == 140,
              k == 123 || k == 131 || k == 138,
              (k >= 131 && k <= 133) ? 2'b00 : 2'b10,
              (k <= 133) ? 2'd2 : 2'd1);
      if (k == 126) hsclk_sel = 1'b0;
      if (k == 131) div_sel = 2'd1;
      if (k == 133) hsclk_sel = 1'b1;
      lsclk_in = wave(k);
    end

    // stretch_req high for the five edges 142..146 at the end of a high phase.
    for (int i = 141; i <= 148; i++) begin
      tick();
`ifdef CLKCTRL_STRETCH_EN
      expect4(k <= 146, k == 147, 2'b10, 2'd1);
`else
      expect4(k == 141 || k == 144 || k == 145 || k == 148,
              k == 142 || k == 146, 2'b10, 2'd1);
`endif
      if (k == 141) stretch_req = 1'b1;
      if (k == 146) stretch_req = 1'b0;
      lsclk_in = wave(k);
    end

    // Reset asserted mid-phase.
    rst_b = 1'b0;
    tick();
    expect4(1'b0, 1'b0, 2'b01, 2'd0);
    tick();
    expect4(1'b0, 1'b0, 2'b01, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
